// File: rtl/seg7_scan_ctrl_if.sv
// Bus between a 7-segment scan controller and its host: display value and
// control strobes in, multiplexed digit/segment drive and status out.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [6:0]              seg;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output en, load, value, lz_blank,
        input  digit_en, seg, frame_done, pending
    );

    modport slave (
        input  en, load, value, lz_blank,
        output digit_en, seg, frame_done, pending
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed BCD 7-segment scanner with a double-buffered display value,
// anti-ghosting gaps between digits and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GAP        = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);
    localparam int CNT_MAX = (PRESCALE > GAP) ? PRESCALE : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_GAP} state_t;

    // The final cycle of a frame is the last gap cycle, or the last dwell cycle without gaps.
    localparam state_t        LAST_STATE = (GAP > 0) ? ST_GAP : ST_DWELL;
    localparam logic [CW-1:0] LAST_CNT   = (GAP > 0) ? GAP_LAST : DWELL_LAST;

    state_t                  state_reg, state_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    pending_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [4*NUM_DIGITS-1:0] active_reg;
    logic [4*NUM_DIGITS-1:0] active_next;
    logic                    frame_end;
    logic                    advance;
    logic                    blank;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upper_zero;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // The new frame's first digit must already see the value transferred at the frame boundary.
    assign active_next = (frame_end && pending_reg) ? shadow_reg : active_reg;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi]        = active_next[4*gi +: 4];
        assign upper_zero[gi] = ~|active_next[4*NUM_DIGITS-1 : 4*gi];
    end

    assign blank = bus.lz_blank && (idx_next != '0) && upper_zero[idx_next];

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        advance    = 1'b0;
        frame_end  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.en) begin
                    state_next = ST_DWELL;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            end
            ST_DWELL: begin
                if (cnt_reg == DWELL_LAST) begin
                    if (GAP > 0) begin
                        state_next = ST_GAP;
                        cnt_next   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (advance) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
                frame_end  = 1'b1;
                idx_next   = '0;
                state_next = bus.en ? ST_DWELL : ST_IDLE;
            end else begin
                idx_next   = idx_reg + IW'(1);
                state_next = ST_DWELL;
            end
        end
    end

    // Segments are latched on dwell entry so lz_blank changes never glitch a lit digit.
    always_comb begin
        digit_en_next   = digit_en_reg;
        seg_next        = seg_reg;
        frame_done_next = (state_next == LAST_STATE) && (cnt_next == LAST_CNT) &&
                          (idx_next == IDX_LAST);
        if (state_next != ST_DWELL) begin
            digit_en_next = '0;
            seg_next      = '0;
        end else if (cnt_next == '0) begin
            digit_en_next = NUM_DIGITS'(1) << idx_next;
            seg_next      = blank ? 7'b0000000 : decode(nib[idx_next]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            digit_en_reg   <= '0;
            seg_reg        <= '0;
            frame_done_reg <= 1'b0;
            pending_reg    <= 1'b0;
            shadow_reg     <= '0;
            active_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            digit_en_reg   <= digit_en_next;
            seg_reg        <= seg_next;
            frame_done_reg <= frame_done_next;
            active_reg     <= active_next;
            if (bus.load) begin
                shadow_reg  <= bus.value;
                pending_reg <= 1'b1;
            end else if (frame_end) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign bus.digit_en   = digit_en_reg;
    assign bus.seg        = seg_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: constant vector table, directed corner
// sequences and a random phase, all compared every cycle with a frame-position model.
module tb_seg7_scan_ctrl;
    localparam int N     = 4;
    localparam int P     = 4;
    localparam int G     = 1;
    localparam int SLOT  = P + G;
    localparam int FRAME = N * SLOT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GAP(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: frame position counter plus the two display buffers.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    bit          m_pending;
    bit          m_lz [N];
    logic [N-1:0] e_digit_en;
    logic [6:0]   e_seg;
    bit           e_fd;

    typedef struct {
        logic [15:0] value;
        bit          lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;
    vec_t vecs [7];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_pending = 0;
        for (int k = 0; k < N; k++) m_lz[k] = 0;
    endtask

    task automatic model_clock();
        bit fe;
        fe = m_run && (m_pos == FRAME - 1);
        if (fe && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (bus.load) begin
            m_shadow  = bus.value;
            m_pending = 1;
        end
        if (m_run) begin
            if (fe) begin
                m_pos = 0;
                m_run = bus.en;
            end else begin
                m_pos++;
            end
        end else if (bus.en) begin
            m_run = 1;
            m_pos = 0;
        end
        if (m_run && (m_pos % SLOT == 0)) m_lz[m_pos / SLOT] = bus.lz_blank;
    endtask

    task automatic compute_expect();
        int d;
        int w;
        e_digit_en = '0;
        e_seg      = '0;
        e_fd       = m_run && (m_pos == FRAME - 1);
        if (m_run) begin
            d = m_pos / SLOT;
            w = m_pos % SLOT;
            if (w < P) begin
                e_digit_en = N'(1 << d);
                if (m_lz[d] && d > 0 && (m_active >> (4 * d)) == 16'h0)
                    e_seg = 7'b0000000;
                else
                    e_seg = seg_of(int'(m_active[4*d +: 4]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        compute_expect();
        #1;
        check("digit_en",   32'(bus.digit_en),   32'(e_digit_en));
        check("seg",        32'(bus.seg),        32'(e_seg));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("pending",    32'(bus.pending),    32'(m_pending));
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.frame_done !== 1'b1 && n < 3 * FRAME);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: frame_done=%b expected 1 within %0d cycles", name, bus.frame_done, 3 * FRAME);
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_digit_en",   32'(bus.digit_en),   32'h0);
        check("rst_seg",        32'(bus.seg),        32'h0);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        check("rst_pending",    32'(bus.pending),    32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] cap [N];
        int seen3;
        int n;

        vecs[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h0050, 1'b1, {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
        vecs[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[3] = '{16'h0A00, 1'b0, {7'b1111110, 7'b0000000, 7'b1111110, 7'b1111110}};
        vecs[4] = '{16'h5678, 1'b0, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}};
        vecs[5] = '{16'h9000, 1'b1, {7'b1110011, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[6] = '{16'h0A00, 1'b1, {7'b0000000, 7'b0000000, 7'b1111110, 7'b1111110}};

        rst_n = 1'b0;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.lz_blank = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_digit_en",   32'(bus.digit_en),   32'h0);
        check("reset_seg",        32'(bus.seg),        32'h0);
        check("reset_frame_done", 32'(bus.frame_done), 32'h0);
        check("reset_pending",    32'(bus.pending),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load 0x1234 while idle: first frame still shows the zero active value.
        bus.value = 16'h1234; bus.load = 1'b1;
        step();
        bus.load = 1'b0; bus.en = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int k = 0; k < N; k++) if (bus.digit_en === N'(1 << k)) cap[k] = bus.seg;
            if (c == FRAME - 1) check("frame_len_fd", 32'(bus.frame_done), 32'h1);
        end
        for (int k = 0; k < N; k++) check("first_frame_seg", 32'(cap[k]), 32'(7'b1111110));
        check("first_frame_pending", 32'(bus.pending), 32'h1);
        step();
        check("xfer_pending",  32'(bus.pending),  32'h0);
        check("xfer_digit_en", 32'(bus.digit_en), 32'h1);
        check("xfer_seg",      32'(bus.seg),      32'(7'b0110011));
        $display("seq first_frame: errors so far %0d", errors);

        foreach (vecs[i]) begin
            bus.value = vecs[i].value; bus.lz_blank = vecs[i].lz; bus.load = 1'b1;
            step();
            bus.load = 1'b0;
            wait_fd("tbl");
            for (int k = 0; k < N; k++) cap[k] = 'x;
            for (int c = 0; c < FRAME; c++) begin
                step();
                for (int k = 0; k < N; k++) if (bus.digit_en === N'(1 << k)) cap[k] = bus.seg;
            end
            for (int k = 0; k < N; k++) begin
                logic [27:0] s;
                s = vecs[i].segs;
                check("tbl_seg", 32'(cap[k]), 32'(s[7*k +: 7]));
            end
            $display("vec %0d value=%h lz=%0b segs=%b_%b_%b_%b", i, vecs[i].value, vecs[i].lz,
                     cap[3], cap[2], cap[1], cap[0]);
        end

        // Load coincident with frame end: old shadow displayed, new one stays pending.
        bus.lz_blank = 1'b0; bus.value = 16'h1111; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_fd("s33a");
        wait_fd("s33b");
        bus.value = 16'h9999; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check("coinc_pending",  32'(bus.pending),  32'h1);
        check("coinc_digit_en", 32'(bus.digit_en), 32'h1);
        check("coinc_seg",      32'(bus.seg),      32'(7'b0110000));
        wait_fd("s33c");
        step();
        check("coinc2_pending", 32'(bus.pending), 32'h0);
        check("coinc2_seg",     32'(bus.seg),     32'(7'b1110011));
        $display("seq load_at_frame_end: errors so far %0d", errors);

        // en dropped during digit1: frame completes, then idle.
        repeat (5) step();
        bus.en = 1'b0;
        seen3 = 0; n = 0;
        do begin
            step();
            n++;
            if (bus.digit_en === 4'b1000) seen3++;
        end while (bus.frame_done !== 1'b1 && n < 3 * FRAME);
        check("endrop_fd",     32'(bus.frame_done), 32'h1);
        check("endrop_digit3", 32'(seen3),          32'(P));
        step();
        check("endrop_idle_digit_en", 32'(bus.digit_en), 32'h0);
        check("endrop_idle_seg",      32'(bus.seg),      32'h0);
        repeat (3) step();
        $display("seq en_drop: errors so far %0d", errors);

        // Async reset mid-dwell of digit2, then restart.
        bus.en = 1'b1;
        repeat (12) step();
        check("pre_rst_digit_en", 32'(bus.digit_en), 32'h4);
        async_reset();
        step();
        check("restart_digit_en", 32'(bus.digit_en), 32'h1);
        $display("seq async_reset: errors so far %0d", errors);

        // Random phase against the model.
        for (int c = 0; c < 900; c++) begin
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.load = ($urandom_range(0, 11) == 0);
            bus.value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 23) == 0) bus.lz_blank = ~bus.lz_blank;
            if (c == 450) async_reset();
            step();
        end
        bus.load = 1'b0;
        $display("seq random: errors so far %0d", errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of time-multiplexed digits, range 1..8.
REQ-002 Parameter PRESCALE, default 1000: clock cycles each digit is lit (dwell), minimum 1.
REQ-003 Parameter GAP, default 2: all-off cycles between digits (anti-ghosting); 0 means no gap.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  scan enable.
REQ-007 load  input  1  single-cycle strobe that captures value into the shadow register.
REQ-008 value  input  4*NUM_DIGITS  BCD digits; digit 0 (rightmost) is value[3:0].
REQ-009 lz_blank  input  1  leading-zero blanking enable.
REQ-010 digit_en  output  NUM_DIGITS  one-hot digit drive, active-high, registered.
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g} with a as MSB, active-high, registered.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-013 pending  output  1  high while the shadow holds a value not yet shown.

Function
REQ-014 States: IDLE, DWELL, GAP; digit index idx runs 0..NUM_DIGITS-1; dwell/gap counter sized for max(PRESCALE,GAP).
REQ-015 IDLE: digit_en=0, seg=0; when en is sampled 1, go to DWELL with idx=0, so digit_en[0] rises at that same edge.
REQ-016 DWELL: digit_en=one-hot(idx), seg=decode(active digit idx), held exactly PRESCALE cycles, then GAP (or directly to next-digit handling when GAP=0).
REQ-017 GAP: digit_en=0, seg=0 for exactly GAP cycles.
REQ-018 After GAP with idx<NUM_DIGITS-1: idx increments and the state returns to DWELL.
REQ-019 After GAP with idx=NUM_DIGITS-1 (frame end): idx returns to 0, frame_done pulses for 1 cycle, the state goes to DWELL if en=1, else IDLE.
REQ-020 Frame length is NUM_DIGITS*(PRESCALE+GAP) cycles; consecutive frames have no extra cycles.
REQ-021 en deasserted mid-frame has no effect until the frame end; the frame always completes and frame_done always fires.
REQ-022 Decode: 0→1111110, 1→0110000, 2→1101101, 3→1111001, 4→0110011, 5→1011011, 6→1011111, 7→1110000, 8→1111111, 9→1110011, 10..15→0000000.
REQ-023 load=1: shadow<=value and pending<=1 at that edge; load is accepted in any state.
REQ-024 At frame end with pending=1: active<=shadow and pending<=0; the displayed value changes only on frame boundaries.
REQ-025 load coincident with frame end: active<=old shadow, shadow<=new value, pending stays 1.
REQ-026 lz_blank=1: a digit k>0 shows seg=0 (digit_en still asserted) when active nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never blanked by lz_blank.
REQ-027 lz_blank is sampled continuously; a change takes effect at the next DWELL entry.

Reset
REQ-028 rst_n=0 immediately forces state=IDLE, idx=0, counter=0, digit_en=0, seg=0, frame_done=0, pending=0, shadow=0, active=0.
REQ-029 Reset mid-DWELL or mid-GAP aborts the frame, with no frame_done and no shadow transfer; scanning restarts from idx 0 once en is sampled after release.

Verification (NUM_DIGITS=4, PRESCALE=4, GAP=1)
REQ-030 Load 0x1234, then en=1 → the first frame shows all 1111110 with pending=1; after frame_done, pending=0 and digit0..3 show 0110011, 1111001, 1101101, 0110000, each lit 4 cycles with a 1-cycle all-off gap, frame=20 cycles.
REQ-031 Active 0x0050, lz_blank=1 → digit3=0000000, digit2=0000000, digit1=1011011, digit0=1111110; active 0x0000 → only digit0 shows 1111110.
REQ-032 Active nibble 0xA on digit2 → seg=0000000 while digit_en=0100.
REQ-033 load of 0x9999 in the cycle frame_done asserts, with shadow=0x1111 → the next frame shows 0110000 on all digits with pending=1; the following frame shows 1110011 with pending=0.
REQ-034 en dropped during digit1 dwell → digits 2 and 3 still scan, frame_done pulses, then IDLE with digit_en=0 and seg=0.
REQ-035 rst_n low mid-dwell of digit2 → digit_en=0 and seg=0 without waiting for a clock edge; after release with en=1, digit_en=0001 on the first edge.
